// File: rtl/int_div_pkg.sv
// Shared types and constants for the iterative integer divider.
package int_div_pkg;

  localparam int unsigned XLEN_DEFAULT = 64;
  localparam int unsigned DIV_STEPS    = XLEN_DEFAULT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/int_div_cseladd.sv
// Carry-select adder: each block precomputes sums for carry-in 0 and 1,
// and the rippled block carry picks one of them.
module int_div_cseladd #(
  parameter int unsigned W   = 65,
  parameter int unsigned BLK = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o
);

  localparam int unsigned NB = (W + BLK - 1) / BLK;

  logic [NB-1:0] blk_c;

  assign blk_c[0] = cin_i;

  for (genvar g = 0; g < NB; g++) begin : g_blk
    localparam int unsigned LO = g * BLK;
    localparam int unsigned BW = ((W - LO) < BLK) ? (W - LO) : BLK;

    if (g == NB - 1) begin : g_last
      // The top block's carry-out leaves the adder, so it is not formed.
      logic [BW-1:0] s0, s1;
      assign s0 = a_i[LO +: BW] + b_i[LO +: BW];
      assign s1 = a_i[LO +: BW] + b_i[LO +: BW] + BW'(1);
      assign sum_o[LO +: BW] = blk_c[g] ? s1 : s0;
    end else begin : g_mid
      logic [BW:0] s0, s1;
      assign s0 = {1'b0, a_i[LO +: BW]} + {1'b0, b_i[LO +: BW]};
      assign s1 = {1'b0, a_i[LO +: BW]} + {1'b0, b_i[LO +: BW]} + (BW+1)'(1);
      assign sum_o[LO +: BW] = blk_c[g] ? s1[BW-1:0] : s0[BW-1:0];
      assign blk_c[g+1]      = blk_c[g] ? s1[BW]     : s0[BW];
    end
  end

endmodule

// File: rtl/int_div.sv
// Restoring radix-2 integer divider, signed or unsigned, one quotient bit
// per cycle; result packs {remainder, quotient}.
module int_div
  import int_div_pkg::*;
#(
  parameter int unsigned XLEN = DIV_STEPS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   inp1,
  input  logic [XLEN-1:0]   inp2,
  input  logic              is_signed,
  input  logic              start,
  output logic              busy,
  output logic              ready,
  output logic [2*XLEN-1:0] int_div_out
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                               input logic            en);
    return en ? (~v + XLEN'(1)) : v;
  endfunction

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   dvd_q, dvd_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic              sgn_q, sgn_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic [2*XLEN-1:0] out_q, out_d;

  logic [XLEN-1:0] dvs_mag;
  logic [XLEN:0]   sub_a, sub_b, sub_diff;
  logic            step_ge;
  logic [XLEN-1:0] quo_step, rem_step;
  logic            dvs_zero, neg_quo, neg_rem, last_step;

  assign dvs_mag   = cond_neg(dvs_q, sgn_q & dvs_q[XLEN-1]);
  assign dvs_zero  = ~|dvs_q;
  assign last_step = (cnt_q == CNT_W'(XLEN - 1));
  assign neg_quo   = sgn_q & (dvd_q[XLEN-1] ^ dvs_q[XLEN-1]);
  assign neg_rem   = sgn_q & dvd_q[XLEN-1];

  // Shift the next dividend bit into the partial remainder, then trial-subtract.
  assign sub_a = {rem_q, quo_q[XLEN-1]};
  assign sub_b = ~{1'b0, dvs_mag};

  int_div_cseladd #(
    .W   (XLEN + 1),
    .BLK (8)
  ) u_sub (
    .a_i   (sub_a),
    .b_i   (sub_b),
    .cin_i (1'b1),
    .sum_o (sub_diff)
  );

  assign step_ge  = ~sub_diff[XLEN];
  assign rem_step = step_ge ? sub_diff[XLEN-1:0] : sub_a[XLEN-1:0];
  assign quo_step = {quo_q[XLEN-2:0], step_ge};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      sgn_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      sgn_q   <= sgn_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    sgn_d   = sgn_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    out_d   = out_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          dvd_d   = inp1;
          dvs_d   = inp2;
          sgn_d   = is_signed;
          quo_d   = cond_neg(inp1, is_signed & inp1[XLEN-1]);
          rem_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        // A zero divisor skips the iteration and finishes on the first step.
        if (dvs_zero) begin
          out_d   = {dvd_q, {XLEN{1'b1}}};
          busy_d  = 1'b0;
          ready_d = 1'b1;
          state_d = DONE;
        end else begin
          quo_d = quo_step;
          rem_d = rem_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_step) begin
            out_d   = {cond_neg(rem_step, neg_rem), cond_neg(quo_step, neg_quo)};
            busy_d  = 1'b0;
            ready_d = 1'b1;
            state_d = DONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  assign busy        = busy_q;
  assign ready       = ready_q;
  assign int_div_out = out_q;

endmodule

// File: tb/tb_int_div.sv
// Directed bench for int_div with an expected-result queue filled at start.
module tb_int_div;

  localparam int XLEN = 64;

  typedef struct {
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;
    int              lat;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [XLEN-1:0]   inp1, inp2;
  logic              is_signed, start;
  logic              busy, ready;
  logic [2*XLEN-1:0] int_div_out;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  int_div #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .inp1        (inp1),
    .inp2        (inp2),
    .is_signed   (is_signed),
    .start       (start),
    .busy        (busy),
    .ready       (ready),
    .int_div_out (int_div_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2*XLEN-1:0] obs,
                     input logic [2*XLEN-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                 input logic s);
    exp_t e;
    logic signed [XLEN-1:0] sa, sbv;
    sa  = a;
    sbv = b;
    e.lat = XLEN;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.lat = 1;
    end else if (s && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1) begin
      e.q = a;
      e.r = '0;
    end else if (s) begin
      e.q = sa / sbv;
      e.r = sa % sbv;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Drives one division; restart_at > 0 pulses start again after that many edges.
  task automatic do_div(input string tag, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic s, input int restart_at);
    exp_t e;
    int   n;
    inp1      = a;
    inp2      = b;
    is_signed = s;
    start     = 1'b1;
    sb.push_back(model(a, b, s));
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy0"}, {127'd0, busy}, 128'd1);
    n = 0;
    while (!ready && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (n == restart_at) begin
        inp1  = 64'd5;
        inp2  = 64'd1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    e = sb.pop_front();
    chk({tag, "_ready"}, {127'd0, ready}, 128'd1);
    chk({tag, "_lat"}, 128'(n), 128'(e.lat));
    chk({tag, "_quo"}, {64'd0, int_div_out[XLEN-1:0]}, {64'd0, e.q});
    chk({tag, "_rem"}, {64'd0, int_div_out[2*XLEN-1:XLEN]}, {64'd0, e.r});
    chk({tag, "_busy_rdy"}, {126'd0, busy, ready}, 128'd1);
  endtask

  initial begin
    logic [2*XLEN-1:0] held;
    logic              seen;
    rst       = 1'b0;
    start     = 1'b0;
    inp1      = '0;
    inp2      = '0;
    is_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {busy, ready, int_div_out}, '0);
    rst = 1'b1;

    do_div("u100_7",   64'd100, 64'd7, 1'b0, 0);
    held = int_div_out;
    repeat (3) @(posedge clk);
    #1;
    chk("done_hold", {ready, int_div_out}, {1'b1, held});

    do_div("s_m7_2",   -64'sd7, 64'd2, 1'b1, 0);
    do_div("u_div0",   64'h1234, 64'd0, 1'b0, 0);
    do_div("s_div0",   -64'sd5, 64'd0, 1'b1, 0);
    do_div("s_ovf",    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0);
    do_div("u_big",    64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b0, 0);
    do_div("u_small",  64'd5, 64'd9, 1'b0, 0);
    do_div("s_7_m2",   64'd7, -64'sd2, 1'b1, 0);
    do_div("s_m100_m7", -64'sd100, -64'sd7, 1'b1, 0);
    do_div("u_neg_bits", -64'sd100, 64'd7, 1'b0, 0);
    do_div("restart",  64'd100, 64'd7, 1'b0, 10);

    // Abort mid-calculation with an asynchronous reset pulse.
    inp1      = 64'd1000;
    inp2      = 64'd7;
    is_signed = 1'b0;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    chk("abort_clear", {busy, ready, int_div_out}, '0);
    @(posedge clk); #1;
    rst  = 1'b1;
    seen = 1'b0;
    repeat (70) begin
      @(posedge clk); #1;
      seen = seen | ready | busy;
    end
    chk("abort_no_result", {127'd0, seen}, 128'd0);

    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    do_div("post_rst_9_3", 64'd9, 64'd3, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
